// File: rtl/ulpi_reg_init.sv
// Power-up sequencer for the ULPI register-access block: writes Function Control and
// OTG Control, reads Function Control back to verify it, and retries or times out accesses.
// state      | meaning
// WAIT_READY | register block not usable yet, or POR delay still running
// ISSUE      | one-cycle REG_EN strobe for the current step
// WAIT_RESP  | waiting for REG_DONE / REG_FAIL, or for the timeout
// VERIFY     | compare the latched readback with FUNC_CTRL_VAL
// DONE       | sequence verified; waiting for START
// ERROR      | sequence aborted; ERR_CODE holds the cause
module ulpi_reg_init #(
    parameter logic [7:0]  FUNC_CTRL_VAL  = 8'h45,
    parameter logic [7:0]  OTG_CTRL_VAL   = 8'h00,
    parameter logic [15:0] POR_DELAY      = 16'd600,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023,
    parameter logic [3:0]  MAX_RETRY      = 4'd3
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic       START,
    input  logic       READY,
    input  logic       REG_DONE,
    input  logic       REG_FAIL,
    input  logic [7:0] REG_DATA_O,
    output logic       REG_EN,
    output logic       REG_RW,
    output logic [5:0] REG_ADDR,
    output logic [7:0] REG_DATA_I,
    output logic       INIT_DONE,
    output logic       INIT_ERR,
    output logic [1:0] ERR_CODE,
    output logic [7:0] READBACK
);

    typedef enum logic [2:0] {
        WAIT_READY,
        ISSUE,
        WAIT_RESP,
        VERIFY,
        DONE,
        ERROR
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  step, step_nxt;
    logic [3:0]  retry, retry_nxt, retry_inc;
    logic [15:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]  err_code, err_nxt;
    logic [7:0]  readback, readback_nxt;

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state    <= WAIT_READY;
            step     <= 2'd0;
            retry    <= 4'd0;
            cnt      <= 16'd0;
            err_code <= 2'b00;
            readback <= 8'h00;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            retry    <= retry_nxt;
            cnt      <= cnt_nxt;
            err_code <= err_nxt;
            readback <= readback_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        retry_nxt    = retry;
        cnt_nxt      = cnt;
        err_nxt      = err_code;
        readback_nxt = readback;
        retry_inc    = (retry == MAX_RETRY) ? retry : retry + 4'd1;
        cnt_inc      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

        case (state)
            WAIT_READY: begin
                if (!READY) begin
                    cnt_nxt = 16'd0;
                end else if (cnt == POR_DELAY - 16'd1) begin
                    cnt_nxt   = 16'd0;
                    state_nxt = ISSUE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ISSUE: begin
                cnt_nxt   = 16'd0;
                state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                cnt_nxt = cnt_inc;
                if (!READY) begin
                    cnt_nxt   = 16'd0;
                    step_nxt  = 2'd0;
                    retry_nxt = 4'd0;
                    state_nxt = WAIT_READY;
                end else if (REG_FAIL) begin
                    retry_nxt = retry_inc;
                    if (retry_inc == MAX_RETRY) begin
                        err_nxt   = 2'b01;
                        state_nxt = ERROR;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end else if (REG_DONE) begin
                    retry_nxt = 4'd0;
                    if (step == 2'd2) begin
                        readback_nxt = REG_DATA_O;
                        state_nxt    = VERIFY;
                    end else begin
                        step_nxt  = step + 2'd1;
                        state_nxt = ISSUE;
                    end
                // counter hits TIMEOUT_CYCLES-1 as it steps, so ERROR lands TIMEOUT_CYCLES after ISSUE
                end else if (cnt_inc == TIMEOUT_CYCLES - 16'd1) begin
                    err_nxt   = 2'b10;
                    state_nxt = ERROR;
                end
            end
            VERIFY: begin
                if (readback == FUNC_CTRL_VAL) begin
                    state_nxt = DONE;
                end else begin
                    err_nxt   = 2'b11;
                    state_nxt = ERROR;
                end
            end
            DONE, ERROR: begin
                if (START) begin
                    err_nxt   = 2'b00;
                    step_nxt  = 2'd0;
                    retry_nxt = 4'd0;
                    cnt_nxt   = 16'd0;
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = WAIT_READY;
        endcase
    end

    // Access fields are only driven while an access is in flight, so reset leaves them at 0.
    always_comb begin
        REG_RW     = 1'b0;
        REG_ADDR   = 6'h00;
        REG_DATA_I = 8'h00;
        if (state == ISSUE || state == WAIT_RESP) begin
            case (step)
                2'd0: begin
                    REG_RW     = 1'b1;
                    REG_ADDR   = 6'h04;
                    REG_DATA_I = FUNC_CTRL_VAL;
                end
                2'd1: begin
                    REG_RW     = 1'b1;
                    REG_ADDR   = 6'h0A;
                    REG_DATA_I = OTG_CTRL_VAL;
                end
                default: begin
                    REG_RW     = 1'b0;
                    REG_ADDR   = 6'h04;
                    REG_DATA_I = 8'h00;
                end
            endcase
        end
    end

    assign REG_EN    = (state == ISSUE);
    assign INIT_DONE = (state == DONE);
    assign INIT_ERR  = (state == ERROR);
    assign ERR_CODE  = err_code;
    assign READBACK  = readback;

endmodule

// File: tb/tb_ulpi_reg_init.sv
// Self-checking bench for ulpi_reg_init: directed scenarios plus randomized PHY responses
// checked against a step/retry model of the configuration sequence.
module tb_ulpi_reg_init;

    logic       CLK_60M = 1'b0;
    logic       NRST_A_USB;
    logic       START;
    logic       READY;
    logic       REG_DONE;
    logic       REG_FAIL;
    logic [7:0] REG_DATA_O;
    logic       REG_EN;
    logic       REG_RW;
    logic [5:0] REG_ADDR;
    logic [7:0] REG_DATA_I;
    logic       INIT_DONE;
    logic       INIT_ERR;
    logic [1:0] ERR_CODE;
    logic [7:0] READBACK;

    int checks = 0;
    int failures = 0;

    localparam int POR = 600;
    localparam int TMO = 1023;

    ulpi_reg_init dut (
        .CLK_60M(CLK_60M), .NRST_A_USB(NRST_A_USB), .START(START), .READY(READY),
        .REG_DONE(REG_DONE), .REG_FAIL(REG_FAIL), .REG_DATA_O(REG_DATA_O),
        .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR), .REG_DATA_I(REG_DATA_I),
        .INIT_DONE(INIT_DONE), .INIT_ERR(INIT_ERR), .ERR_CODE(ERR_CODE), .READBACK(READBACK)
    );

    always #5 CLK_60M = ~CLK_60M;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Fixed step table: {rw, addr, data}
    function automatic logic [14:0] exp_fields(input int s);
        case (s)
            0:       return {1'b1, 6'h04, 8'h45};
            1:       return {1'b1, 6'h0A, 8'h00};
            default: return {1'b0, 6'h04, 8'h00};
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK_60M);
        #1;
    endtask

    task automatic wait_en(input int limit, output int n, output bit ok);
        n = 0;
        ok = 0;
        while (n <= limit) begin
            if (REG_EN) begin
                ok = 1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic wait_flag(input int limit, output int n, output bit ok);
        n = 0;
        ok = 0;
        while (n <= limit) begin
            if (INIT_DONE || INIT_ERR) begin
                ok = 1;
                break;
            end
            tick();
            n++;
        end
    endtask

    // One-cycle PHY response, lat >= 1 cycles after the REG_EN cycle.
    task automatic pulse(input bit fail, input logic [7:0] d, input int lat);
        repeat (lat) tick();
        REG_FAIL = fail;
        REG_DONE = !fail;
        REG_DATA_O = d;
        tick();
        REG_FAIL = 0;
        REG_DONE = 0;
        REG_DATA_O = 8'($urandom);
    endtask

    task automatic start_rerun();
        START = 1;
        tick();
        START = 0;
    endtask

    task automatic test_reset();
        int seen;
        NRST_A_USB = 0; START = 0; READY = 0; REG_DONE = 0; REG_FAIL = 0; REG_DATA_O = 8'h00;
        repeat (3) tick();
        checks++;
        if ({REG_EN, REG_RW, REG_ADDR, REG_DATA_I, INIT_DONE, INIT_ERR, ERR_CODE, READBACK} !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {REG_EN, REG_RW, REG_ADDR, REG_DATA_I, INIT_DONE, INIT_ERR, ERR_CODE, READBACK});
        end
        NRST_A_USB = 1;
        seen = 0;
        repeat (20) begin
            tick();
            if (REG_EN) seen++;
        end
        start_rerun();
        if (REG_EN) seen++;
        tick();
        if (REG_EN) seen++;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL no_access_without_ready: got %0d REG_EN cycles expected 0", seen);
        end
    endtask

    task automatic test_nominal();
        int n;
        bit ok;
        READY = 1;
        for (int s = 0; s < 3; s++) begin
            wait_en(POR + 50, n, ok);
            checks++;
            if (!ok || n != ((s == 0) ? POR : 0)) begin
                failures++;
                $display("FAIL nominal_en_latency step%0d: got %0d (found=%0d) expected %0d", s, n, ok, (s == 0) ? POR : 0);
            end
            checks++;
            if ({REG_RW, REG_ADDR, REG_DATA_I} !== exp_fields(s)) begin
                failures++;
                $display("FAIL nominal_fields step%0d: got %h expected %h", s, {REG_RW, REG_ADDR, REG_DATA_I}, exp_fields(s));
            end
            pulse(0, 8'h45, $urandom_range(1, 4));
        end
        wait_flag(10, n, ok);
        checks++;
        if ({INIT_DONE, INIT_ERR, ERR_CODE, READBACK} !== {1'b1, 1'b0, 2'b00, 8'h45}) begin
            failures++;
            $display("FAIL nominal_result: got %h expected %h", {INIT_DONE, INIT_ERR, ERR_CODE, READBACK}, {1'b1, 1'b0, 2'b00, 8'h45});
        end
    endtask

    task automatic test_abort_retry();
        int n;
        bit ok;
        start_rerun();
        wait_en(20, n, ok);
        pulse(0, 8'h00, 2);
        wait_en(20, n, ok);
        pulse(1, 8'h00, 3);
        checks++;
        if (REG_EN !== 1'b1 || {REG_RW, REG_ADDR, REG_DATA_I} !== exp_fields(1)) begin
            failures++;
            $display("FAIL abort_reissue: got en=%b fields=%h expected en=1 fields=%h", REG_EN, {REG_RW, REG_ADDR, REG_DATA_I}, exp_fields(1));
        end
        tick();
        checks++;
        if (REG_EN !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_back_to_back: got REG_EN=%b expected 0", REG_EN);
        end
        pulse(0, 8'h00, 1);
        wait_en(20, n, ok);
        pulse(0, 8'h45, 2);
        wait_flag(10, n, ok);
        checks++;
        if ({INIT_DONE, INIT_ERR, ERR_CODE} !== 4'b1000) begin
            failures++;
            $display("FAIL abort_result: got %b expected 1000", {INIT_DONE, INIT_ERR, ERR_CODE});
        end
    endtask

    task automatic test_retry_exhausted();
        int n, pulses;
        bit ok;
        start_rerun();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            wait_en(20, n, ok);
            if (!ok) break;
            pulses++;
            pulse(1, 8'h00, $urandom_range(1, 5));
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL retry_pulse_count: got %0d expected 3", pulses);
        end
        checks++;
        if ({INIT_DONE, INIT_ERR, ERR_CODE} !== 4'b0101) begin
            failures++;
            $display("FAIL retry_result: got %b expected 0101", {INIT_DONE, INIT_ERR, ERR_CODE});
        end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        start_rerun();
        for (int s = 0; s < 2; s++) begin
            wait_en(20, n, ok);
            pulse(0, 8'h00, 1);
        end
        wait_en(20, n, ok);
        wait_flag(TMO + 50, n, ok);
        checks++;
        if (!ok || n != TMO) begin
            failures++;
            $display("FAIL timeout_latency: got %0d (found=%0d) expected %0d", n, ok, TMO);
        end
        checks++;
        if ({INIT_DONE, INIT_ERR, ERR_CODE, READBACK} !== {1'b0, 1'b1, 2'b10, 8'h45}) begin
            failures++;
            $display("FAIL timeout_result: got %h expected %h", {INIT_DONE, INIT_ERR, ERR_CODE, READBACK}, {1'b0, 1'b1, 2'b10, 8'h45});
        end
    endtask

    task automatic test_mismatch_rerun();
        int n;
        bit ok;
        start_rerun();
        for (int s = 0; s < 3; s++) begin
            wait_en(20, n, ok);
            pulse(0, 8'h41, 2);
        end
        wait_flag(10, n, ok);
        checks++;
        if ({INIT_DONE, INIT_ERR, ERR_CODE, READBACK} !== {1'b0, 1'b1, 2'b11, 8'h41}) begin
            failures++;
            $display("FAIL mismatch_result: got %h expected %h", {INIT_DONE, INIT_ERR, ERR_CODE, READBACK}, {1'b0, 1'b1, 2'b11, 8'h41});
        end
        start_rerun();
        checks++;
        if ({INIT_DONE, INIT_ERR, ERR_CODE, REG_EN, READBACK} !== {1'b0, 1'b0, 2'b00, 1'b1, 8'h41}) begin
            failures++;
            $display("FAIL rerun_clear: got %h expected %h", {INIT_DONE, INIT_ERR, ERR_CODE, REG_EN, READBACK}, {1'b0, 1'b0, 2'b00, 1'b1, 8'h41});
        end
        for (int s = 0; s < 3; s++) begin
            wait_en(20, n, ok);
            pulse(0, 8'h45, 1);
        end
        wait_flag(10, n, ok);
        checks++;
        if ({INIT_DONE, INIT_ERR, READBACK} !== {1'b1, 1'b0, 8'h45}) begin
            failures++;
            $display("FAIL rerun_result: got %h expected %h", {INIT_DONE, INIT_ERR, READBACK}, {1'b1, 1'b0, 8'h45});
        end
    endtask

    task automatic test_ready_loss();
        int n, seen;
        bit ok;
        start_rerun();
        wait_en(20, n, ok);
        pulse(0, 8'h00, 1);
        wait_en(20, n, ok);
        tick();
        tick();
        READY = 0;
        seen = 0;
        repeat (5) begin
            tick();
            if (REG_EN || INIT_DONE || INIT_ERR) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL ready_loss_idle: got %0d active cycles expected 0", seen);
        end
        READY = 1;
        wait_en(POR + 50, n, ok);
        checks++;
        if (!ok || n != POR || {REG_RW, REG_ADDR, REG_DATA_I} !== exp_fields(0)) begin
            failures++;
            $display("FAIL ready_loss_restart: got n=%0d fields=%h expected n=%0d fields=%h", n, {REG_RW, REG_ADDR, REG_DATA_I}, POR, exp_fields(0));
        end
        pulse(0, 8'h00, 1);
        for (int s = 1; s < 3; s++) begin
            wait_en(20, n, ok);
            pulse(0, 8'h45, 1);
        end
        wait_flag(10, n, ok);
    endtask

    task automatic test_random(input int trials);
        int n, lat, s, r, exp_err;
        bit ok, fail, fin;
        logic [7:0] d, rb;
        rb = 8'h45;
        for (int t = 0; t < trials; t++) begin
            start_rerun();
            s = 0; r = 0; fin = 0; exp_err = 0;
            while (!fin) begin
                wait_en(40, n, ok);
                checks++;
                if (!ok || {REG_RW, REG_ADDR, REG_DATA_I} !== exp_fields(s)) begin
                    failures++;
                    $display("FAIL random_access t%0d: got en=%b fields=%h expected en=1 fields=%h", t, ok, {REG_RW, REG_ADDR, REG_DATA_I}, exp_fields(s));
                    break;
                end
                fail = ($urandom_range(0, 2) == 0);
                lat = $urandom_range(1, 6);
                d = ($urandom_range(0, 1) == 1) ? 8'h45 : 8'($urandom);
                pulse(fail, d, lat);
                if (fail) begin
                    r++;
                    if (r == 3) begin
                        fin = 1;
                        exp_err = 1;
                    end
                end else begin
                    r = 0;
                    if (s == 2) begin
                        rb = d;
                        fin = 1;
                        exp_err = (d == 8'h45) ? 0 : 3;
                    end else begin
                        s++;
                    end
                end
            end
            wait_flag(10, n, ok);
            checks++;
            if ({INIT_DONE, INIT_ERR, ERR_CODE, READBACK} !== {exp_err == 0, exp_err != 0, 2'(exp_err), rb}) begin
                failures++;
                $display("FAIL random_result t%0d: got %h expected %h", t, {INIT_DONE, INIT_ERR, ERR_CODE, READBACK}, {exp_err == 0, exp_err != 0, 2'(exp_err), rb});
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        bit ok;
        start_rerun();
        wait_en(20, n, ok);
        pulse(0, 8'h00, 1);
        wait_en(20, n, ok);
        tick();
        #3;
        NRST_A_USB = 0;
        #1;
        checks++;
        if ({REG_EN, REG_RW, REG_ADDR, REG_DATA_I, INIT_DONE, INIT_ERR, ERR_CODE, READBACK} !== 28'h0) begin
            failures++;
            $display("FAIL async_reset_outputs: got %h expected 0",
                     {REG_EN, REG_RW, REG_ADDR, REG_DATA_I, INIT_DONE, INIT_ERR, ERR_CODE, READBACK});
        end
        tick();
        tick();
        NRST_A_USB = 1;
        wait_en(POR + 50, n, ok);
        checks++;
        if (!ok || n != POR || {REG_RW, REG_ADDR, REG_DATA_I} !== exp_fields(0)) begin
            failures++;
            $display("FAIL async_reset_restart: got n=%0d fields=%h expected n=%0d fields=%h", n, {REG_RW, REG_ADDR, REG_DATA_I}, POR, exp_fields(0));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_abort_retry();
        test_retry_exhausted();
        test_timeout();
        test_mismatch_rerun();
        test_ready_loss();
        test_random(8);
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ulpi_reg_init.md
Name: ulpi_reg_init

Overview:
- Power-up configuration sequencer that sits directly upstream of the ULPI register-access block.
- Drives that block's REG_EN / REG_RW / REG_ADDR / REG_DATA_I strobe interface.
- Programs the PHY Function Control and OTG Control registers, then reads Function Control back to verify it.
- Reports INIT_DONE or INIT_ERR to the audio-card top level, retrying PHY-aborted accesses and timing out hung ones.

Parameters:
- FUNC_CTRL_VAL, 8'h45, value written to Function Control (addr 6'h04): FS transceiver, TermSelect=1, OpMode normal, SuspendM=1.
- OTG_CTRL_VAL, 8'h00, value written to OTG Control (addr 6'h0A): pulldowns off (device mode).
- POR_DELAY, 16'd600, cycles to wait after READY first seen high before the first access.
- TIMEOUT_CYCLES, 16'd1023, maximum cycles in WAIT_RESP before declaring a timeout.
- MAX_RETRY, 4'd3, total attempts per step when REG_FAIL is returned.

Ports:
- CLK_60M  in  1  ULPI 60 MHz clock.
- NRST_A_USB  in  1  reset, asynchronous assert, active-low.
- START  in  1  re-run request; honoured only in DONE or ERROR.
- READY  in  1  register block is out of reset and usable.
- REG_DONE  in  1  one-cycle access-complete pulse.
- REG_FAIL  in  1  one-cycle PHY-aborted pulse.
- REG_DATA_O  in  8  read data; valid in the REG_DONE cycle of a read.
- REG_EN  out  1  one-cycle access strobe.
- REG_RW  out  1  1 = write, 0 = read.
- REG_ADDR  out  6  register address.
- REG_DATA_I  out  8  write data.
- INIT_DONE  out  1  sequence completed and verified (level).
- INIT_ERR  out  1  sequence aborted (level).
- ERR_CODE  out  2  00 none, 01 retries exhausted, 10 timeout, 11 readback mismatch.
- READBACK  out  8  last value read from Function Control.

Behaviour:
- Reset (async, NRST_A_USB low):
  - All outputs 0; state WAIT_READY; step=0; counters 0.
  - Reset asserted mid-access aborts immediately; the sequence restarts from step 0 after release.
- Step table, fixed:
  - step0: write 6'h04 / FUNC_CTRL_VAL.
  - step1: write 6'h0A / OTG_CTRL_VAL.
  - step2: read 6'h04.
- REG_RW / REG_ADDR / REG_DATA_I are combinational from step and are stable throughout ISSUE and WAIT_RESP. REG_DATA_I=0 for reads.
- States:
  - WAIT_READY: while READY=0, hold the delay counter at 0. While READY=1, count; when the count reaches POR_DELAY-1, go to ISSUE. Auto-entered after reset, so no START is needed at power-up.
  - ISSUE: REG_EN=1 for exactly this one cycle; clear the timeout counter; go to WAIT_RESP.
  - WAIT_RESP: REG_EN=0; timeout counter increments every cycle. Priority, highest first:
    1. READY=0: go to WAIT_READY, step=0, retry=0.
    2. REG_FAIL=1 (wins over a simultaneous REG_DONE): retry+1. If the new value equals MAX_RETRY, go to ERROR with ERR_CODE=01; else go to ISSUE next cycle.
    3. REG_DONE=1: retry=0. For step2, latch REG_DATA_O into READBACK and go to VERIFY. Otherwise step+1 and go to ISSUE.
    4. Counter reaches TIMEOUT_CYCLES-1: go to ERROR with ERR_CODE=10.
  - VERIFY (1 cycle): if READBACK==FUNC_CTRL_VAL go to DONE, else go to ERROR with ERR_CODE=11.
  - DONE: INIT_DONE=1.
  - ERROR: INIT_ERR=1; ERR_CODE holds its value.
  - From DONE or ERROR, START=1 (sampled on the clock edge) clears INIT_DONE, INIT_ERR, ERR_CODE, step and retry, then enters ISSUE directly with no POR delay. START in any other state is ignored.
- Timing rules:
  - REG_EN may re-pulse the cycle after REG_DONE or REG_FAIL; the register block is back in IDLE then.
  - REG_EN is never asserted in two consecutive cycles.
  - Best-case latency per write, ISSUE to REG_DONE, is set by the PHY (NXT). The sequencer adds 1 cycle per step.
- READBACK persists across START until overwritten by the next read.
- Counters: 16-bit. retry is 4-bit and saturates at MAX_RETRY. Never wraps.

Test Plan:
- Nominal: READY high at t0; PHY model acks every access.
  - Expect REG_EN at t0+600 with RW=1, ADDR=04, DATA=45; then ADDR=0A, DATA=00; then RW=0, ADDR=04.
  - Read returns 8'h45: INIT_DONE=1, ERR_CODE=00, READBACK=45.
- Abort retry: REG_FAIL on the first attempt of step1, then DONE.
  - Expect step1 reissued the cycle after FAIL with identical ADDR/DATA.
  - Sequence completes: INIT_DONE=1.
- Retries exhausted: REG_FAIL on every step0 attempt.
  - Expect exactly 3 REG_EN pulses, then INIT_ERR=1, ERR_CODE=01, INIT_DONE=0.
- Timeout: no response to the step2 read.
  - Expect INIT_ERR=1 and ERR_CODE=10, 1023 cycles after the step2 ISSUE.
- Mismatch and re-run: read returns 8'h41, giving ERR_CODE=11 and READBACK=41.
  - Pulse START; the next read returns 45.
  - Expect flags cleared within 1 cycle of START, REG_EN the cycle after, and final INIT_DONE=1.
- Reset / READY loss:
  - Drop READY during WAIT_RESP of step1: expect return to step0 after a fresh POR_DELAY.
  - Assert NRST_A_USB mid-sequence: all outputs 0 asynchronously.
